// File: rtl/comb_inv.sv
// comb_inv: inverse lookup for the comb 4b->5b code table.
// Scans all 16 entries, one per clock, and reports the preimage set.
module comb_inv (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_code,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_found,
  output logic [3:0] out_first,
  output logic [3:0] out_last,
  output logic [4:0] out_count
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t     state;
  logic [3:0] idx;
  logic [4:0] code_q;
  logic       hit;

  function automatic logic [4:0] fwd(
    input logic [3:0] n
  );
    logic [4:0] c;
    case (n)
      4'h0:    c = 5'b01001;
      4'h1:    c = 5'b00011;
      4'h2:    c = 5'b11111;
      4'h3:    c = 5'b11001;
      4'h4:    c = 5'b01000;
      4'h5:    c = 5'b00110;
      4'h6:    c = 5'b01100;
      4'h7:    c = 5'b01100;
      4'h8:    c = 5'b00011;
      4'h9:    c = 5'b00001;
      4'hA:    c = 5'b01010;
      4'hB:    c = 5'b00100;
      4'hC:    c = 5'b00101;
      4'hD:    c = 5'b11101;
      4'hE:    c = 5'b01001;
      default: c = 5'b01000;
    endcase
    return c;
  endfunction

  // table entry under the scan pointer matches the latched code
  assign hit = (fwd(idx) == code_q);

  // handshake FSM with registered results and handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      code_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_found <= 1'b0;
      out_first <= '0;
      out_last  <= '0;
      out_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            code_q    <= in_code;
            idx       <= '0;
            out_found <= 1'b0;
            out_first <= '0;
            out_last  <= '0;
            out_count <= '0;
            in_ready  <= 1'b0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (hit) begin
            out_count <= out_count + 5'd1;
            out_last  <= idx;
            if (!out_found) begin
              out_first <= idx;
              out_found <= 1'b1;
            end
          end
          // idx wraps to 0 after the last entry
          idx <= idx + 4'd1;
          if (idx == 4'hF) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comb_inv.sv
// tb_comb_inv: directed vectors for comb_inv.
// Expected preimage sets are hand-derived from the code table.
module tb_comb_inv;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_code;
  logic       out_valid;
  logic       out_ready;
  logic       out_found;
  logic [3:0] out_first;
  logic [3:0] out_last;
  logic [4:0] out_count;

  int total = 0;
  int bad   = 0;

  comb_inv dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_found (out_found),
    .out_first (out_first),
    .out_last  (out_last),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [4:0] c);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    chk("rdy_wait", 32'(n < 40), 1);
    in_valid = 1'b1;
    in_code  = c;
    tick();
    in_valid = 1'b0;
    in_code  = 5'h1F;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, 16);
  endtask

  task automatic res(
    input string      tag,
    input logic       f,
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [4:0] c
  );
    chk({tag, "_found"}, out_found, f);
    chk({tag, "_first"}, out_first, a);
    chk({tag, "_last"},  out_last,  b);
    chk({tag, "_count"}, out_count, c);
  endtask

  task automatic run(
    input string      tag,
    input logic [4:0] code,
    input logic       f,
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [4:0] c
  );
    start(code);
    wait_done(tag);
    res(tag, f, a, b, c);
    tick();
    chk({tag, "_hs_ov"}, out_valid, 0);
    chk({tag, "_hs_rdy"}, in_ready, 1);
    res({tag, "_hold"}, f, a, b, c);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_code   = '0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      chk("idle_rdy", in_ready, 1);
      chk("idle_ov", out_valid, 0);
      tick();
    end
    res("rst", 0, 0, 0, 0);

    run("c1f", 5'b11111, 1, 4'h2, 4'h2, 5'd1);
    run("c09", 5'b01001, 1, 4'h0, 4'hE, 5'd2);
    run("c08", 5'b01000, 1, 4'h4, 4'hF, 5'd2);
    run("c0c", 5'b01100, 1, 4'h6, 4'h7, 5'd2);
    run("c03", 5'b00011, 1, 4'h1, 4'h8, 5'd2);
    run("c00", 5'b00000, 0, 4'h0, 4'h0, 5'd0);
    run("c1d", 5'b11101, 1, 4'hD, 4'hD, 5'd1);

    out_ready = 1'b0;
    start(5'b01100);
    wait_done("bp");
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_code  = 5'(i * 7);
      tick();
      chk("bp_ov", out_valid, 1);
      chk("bp_rdy", in_ready, 0);
      res("bp", 1, 4'h6, 4'h7, 5'd2);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_hs_ov", out_valid, 0);
    chk("bp_hs_rdy", in_ready, 1);
    res("bp_hold", 1, 4'h6, 4'h7, 5'd2);
    start(5'b00011);
    chk("b2b_acc", in_ready, 0);
    wait_done("b2b");
    res("b2b", 1, 4'h1, 4'h8, 5'd2);
    tick();

    start(5'b01001);
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_rdy", in_ready, 1);
    chk("mrst_ov", out_valid, 0);
    res("mrst", 0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) n++;
    end
    chk("mrst_noov", n, 0);
    run("c19", 5'b11001, 1, 4'h3, 4'h3, 5'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
